// File: rtl/bios_loader_pkg.sv
// bios_loader_pkg
// Shared types and constants for the HPS ioctl BIOS loader.
//   bl_state_t : loader sequencing states
//   bl_word_t  : one packed BIOS word plus its word address
//   PAD_BYTE   : filler for the high byte of an odd-length image
package bios_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } bl_state_t;

    localparam int BIOS_WORDS  = 8192;
    localparam int BIOS_ADDR_W = $clog2(BIOS_WORDS);

    typedef struct packed {
        logic [BIOS_ADDR_W-1:0] addr;
        logic [15:0]            data;
    } bl_word_t;

    localparam logic [7:0] PAD_BYTE = 8'hFF;

endpackage

// File: rtl/bios_word_fifo.sv
// bios_word_fifo
// Synchronous FIFO of bl_word_t entries with synchronous flush.
// Ports:
//   clk_sys, reset_n   : clock, async active-low reset
//   i_flush            : empty the FIFO (wins over push/pop)
//   i_push, i_data     : write one word
//   i_pop              : drop the head word
//   o_data             : head word (valid while !o_empty)
//   o_full, o_empty    : status
//   o_count            : occupancy, 0..DEPTH
module bios_word_fifo
    import bios_loader_pkg::*;
#(
    parameter int DEPTH = 16
)(
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  bl_word_t                 i_data,
    input  logic                     i_pop,
    output bl_word_t                 o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    bl_word_t          r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_push = i_push & ~o_full & ~i_flush;
    assign w_pop  = i_pop & ~o_empty & ~i_flush;

    always_ff @(posedge clk_sys) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The wait hysteresis upstream leaves headroom; a push into a full
    // FIFO would silently lose a word.
    a_no_push_full: assert property (@(posedge clk_sys) disable iff (!reset_n)
        !(i_push && o_full && !i_flush));

endmodule

// File: rtl/bios_loader.sv
// bios_loader
// Packs the hps_io ioctl BIOS byte stream into 16-bit words, buffers them
// and hands them to the system BIOS write port at the bios_req rate.
// Ports:
//   clk_sys, reset_n                : clock, async active-low reset
//   ioctl_download/wr/addr/dout/index : hps_io download interface
//   ioctl_wait                      : back-pressure to hps_io
//   bios_addr, bios_din, bios_wr    : word presented to the system
//   bios_req                        : system accepts the presented word
//   bios_loaded, cpu_hold           : load status / CPU hold request
//   overflow                        : sticky, byte beyond port range dropped
//   checksum_ok                     : only with BIOS_LOADER_CHECKSUM_EN
// Optional: define BIOS_LOADER_CHECKSUM_EN to require an 8-bit byte sum
// of zero before declaring the image loaded.
//
// state | meaning
// IDLE  | no image, waiting for a matching download
// FILL  | download active, bytes packed into the FIFO
// DRAIN | download ended, flushing remaining words to the system
// DONE  | image transferred, bios_loaded high
module bios_loader
    import bios_loader_pkg::*;
#(
    parameter int         ADDR_W     = 13,
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] BIOS_INDEX = 8'h00
)(
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [7:0]        ioctl_index,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] bios_addr,
    output logic [15:0]       bios_din,
    output logic              bios_wr,
    input  logic              bios_req,
    output logic              bios_loaded,
    output logic              cpu_hold,
    output logic              overflow
`ifdef BIOS_LOADER_CHECKSUM_EN
    ,
    output logic              checksum_ok
`endif
);

    localparam int   CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] WAIT_ON  = CNT_W'(FIFO_DEPTH - 2);
    localparam logic [CNT_W-1:0] WAIT_OFF = CNT_W'(FIFO_DEPTH - 4);

    bl_state_t              r_state;
    logic                   r_dl_q;
    logic [7:0]             r_lo;
    logic [BIOS_ADDR_W-1:0] r_lo_addr;
    logic                   r_half_valid;
    logic                   r_loaded;
    logic                   r_ovf;
    logic                   r_wait;
    logic                   r_wr;
    logic [ADDR_W-1:0]      r_addr;
    logic [15:0]            r_din;

    logic                   w_index_ok;
    logic                   w_start;
    logic                   w_end;
    logic                   w_cap;
    logic                   w_in_range;
    logic                   w_byte_ok;
    logic                   w_pad;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_drained;
    logic                   w_sum_ok;
    bl_word_t               w_push_word;
    bl_word_t               w_fifo_out;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [CNT_W-1:0]       w_fifo_count;

    assign w_index_ok = (ioctl_index == BIOS_INDEX);
    assign w_start    = ioctl_download & ~r_dl_q & w_index_ok;
    assign w_end      = (r_state == FILL) & ~ioctl_download & r_dl_q;
    assign w_cap      = (r_state == FILL) & ioctl_wr & w_index_ok & ~w_end;
    assign w_in_range = (ioctl_addr[24:ADDR_W+1] == '0);
    assign w_byte_ok  = w_cap & w_in_range;
    assign w_pad      = w_end & r_half_valid;
    assign w_push     = (w_byte_ok & ioctl_addr[0]) | w_pad;

    always_comb begin
        w_push_word = '0;
        if (w_pad) begin
            w_push_word.addr = r_lo_addr;
            w_push_word.data = {PAD_BYTE, r_lo};
        end else begin
            w_push_word.addr = BIOS_ADDR_W'(ioctl_addr[ADDR_W:1]);
            w_push_word.data = {ioctl_dout, r_lo};
        end
    end

    // The output stage refills in the same cycle it is consumed, so a word
    // per bios_req pulse is sustained without a bubble.
    assign w_pop     = ~w_fifo_empty & (~r_wr | bios_req) & ~w_start;
    assign w_drained = (r_state == DRAIN) & w_fifo_empty & ~r_wr;

    bios_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .i_flush (w_start),
        .i_push  (w_push),
        .i_data  (w_push_word),
        .i_pop   (w_pop),
        .o_data  (w_fifo_out),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

`ifdef BIOS_LOADER_CHECKSUM_EN
    logic [7:0] r_sum;
    logic       r_cksum_ok;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_sum      <= '0;
            r_cksum_ok <= 1'b0;
        end else if (w_start) begin
            r_sum      <= '0;
            r_cksum_ok <= 1'b0;
        end else begin
            if (w_byte_ok)      r_sum <= r_sum + ioctl_dout;
            else if (w_pad)     r_sum <= r_sum + PAD_BYTE;
            if (w_drained)      r_cksum_ok <= (r_sum == 8'h00);
        end
    end

    assign w_sum_ok    = (r_sum == 8'h00);
    assign checksum_ok = r_cksum_ok;
`else
    assign w_sum_ok = 1'b1;
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_dl_q       <= 1'b0;
            r_lo         <= '0;
            r_lo_addr    <= '0;
            r_half_valid <= 1'b0;
            r_loaded     <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_dl_q <= ioctl_download;
            if (w_start) begin
                r_state      <= FILL;
                r_lo         <= '0;
                r_lo_addr    <= '0;
                r_half_valid <= 1'b0;
                r_loaded     <= 1'b0;
                r_ovf        <= 1'b0;
            end else begin
                case (r_state)
                    FILL: begin
                        if (w_end) begin
                            r_state      <= DRAIN;
                            r_half_valid <= 1'b0;
                        end else if (w_cap) begin
                            if (!w_in_range) begin
                                r_ovf <= 1'b1;
                            end else if (!ioctl_addr[0]) begin
                                r_lo         <= ioctl_dout;
                                r_lo_addr    <= BIOS_ADDR_W'(ioctl_addr[ADDR_W:1]);
                                r_half_valid <= 1'b1;
                            end else begin
                                r_half_valid <= 1'b0;
                            end
                        end
                    end
                    DRAIN: begin
                        if (w_drained) begin
                            if (w_sum_ok) begin
                                r_state  <= DONE;
                                r_loaded <= 1'b1;
                            end else begin
                                r_state  <= IDLE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_wr   <= 1'b0;
            r_addr <= '0;
            r_din  <= '0;
        end else if (w_start) begin
            r_wr   <= 1'b0;
            r_addr <= '0;
            r_din  <= '0;
        end else if (w_pop) begin
            r_wr   <= 1'b1;
            r_addr <= ADDR_W'(w_fifo_out.addr);
            r_din  <= w_fifo_out.data;
        end else if (bios_req) begin
            r_wr   <= 1'b0;
        end
    end

    // Hysteresis keeps wait from chattering as the drain pops single words.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_wait <= 1'b0;
        end else if (w_start) begin
            r_wait <= 1'b0;
        end else if (w_fifo_full || (w_fifo_count >= WAIT_ON)) begin
            r_wait <= 1'b1;
        end else if (w_fifo_count <= WAIT_OFF) begin
            r_wait <= 1'b0;
        end
    end

    assign ioctl_wait  = r_wait;
    assign bios_addr   = r_addr;
    assign bios_din    = r_din;
    assign bios_wr     = r_wr;
    assign bios_loaded = r_loaded;
    assign overflow    = r_ovf;
    assign cpu_hold    = ~r_loaded | (r_state == FILL) | (r_state == DRAIN);

endmodule

// File: tb/tb_bios_loader.sv
// tb_bios_loader
// Scoreboard bench for bios_loader: stimulus pushes expected words, a
// monitor driving bios_req pops and compares every accepted word.
module tb_bios_loader;
    import bios_loader_pkg::*;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [7:0]  ioctl_index = '0;
    logic        ioctl_wait;
    logic [12:0] bios_addr;
    logic [15:0] bios_din;
    logic        bios_wr;
    logic        bios_req = 1'b0;
    logic        bios_loaded;
    logic        cpu_hold;
    logic        overflow;
`ifdef BIOS_LOADER_CHECKSUM_EN
    logic        checksum_ok;
`endif

    bios_loader dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .ioctl_wait     (ioctl_wait),
        .bios_addr      (bios_addr),
        .bios_din       (bios_din),
        .bios_wr        (bios_wr),
        .bios_req       (bios_req),
        .bios_loaded    (bios_loaded),
        .cpu_hold       (cpu_hold),
        .overflow       (overflow)
`ifdef BIOS_LOADER_CHECKSUM_EN
        ,
        .checksum_ok    (checksum_ok)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    bl_word_t sb[$];
    int errors = 0;
    int checks = 0;
    int words_seen = 0;
    int req_period = 0;
    int cyc = 0;
    int bytes_sent = 0;
    int first_wait_bytes = -1;
    logic first_wait_seen = 1'b0;
    logic abort_tx = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic expect_word(input logic [12:0] a, input logic [15:0] d);
        bl_word_t w;
        w.addr = a;
        w.data = d;
        sb.push_back(w);
    endtask

    task automatic start_dl(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick(2);
    endtask

    task automatic end_dl();
        ioctl_download = 1'b0;
        tick(1);
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        int guard = 0;
        while (ioctl_wait && guard < 2000) begin
            if (!first_wait_seen) begin
                first_wait_seen  = 1'b1;
                first_wait_bytes = bytes_sent;
            end
            tick();
            guard++;
        end
        if (guard >= 2000) begin
            checks++;
            errors++;
            $display("FAIL wait_timeout: ioctl_wait still %0b after %0d cycles, required 0", ioctl_wait, guard);
        end
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
        bytes_sent++;
    endtask

    task automatic wait_loaded(input string name, input int limit);
        int n = 0;
        while (!bios_loaded && n < limit) begin
            tick();
            n++;
        end
        check(name, bios_loaded, 1);
    endtask

    // Monitor: decides bios_req at each falling edge; a word is consumed at
    // the next rising edge when both req and wr are high.
    initial begin
        bl_word_t e;
        forever begin
            @(negedge clk_sys);
            cyc++;
            if (!reset_n) begin
                bios_req = 1'b0;
            end else begin
                bios_req = (req_period != 0) && ((cyc % req_period) == 0);
                if (bios_req && bios_wr) begin
                    words_seen++;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got addr %0h data %0h expected none", bios_addr, bios_din);
                    end else begin
                        e = sb.pop_front();
                        check("word_addr", {19'd0, bios_addr}, {19'd0, e.addr});
                        check("word_data", {16'd0, bios_din}, {16'd0, e.data});
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

    initial begin
        int w0;
        tick(3);
        check("rst_wait",    ioctl_wait, 0);
        check("rst_addr",    bios_addr, 0);
        check("rst_din",     bios_din, 0);
        check("rst_wr",      bios_wr, 0);
        check("rst_loaded",  bios_loaded, 0);
        check("rst_hold",    cpu_hold, 1);
        check("rst_ovf",     overflow, 0);
        reset_n = 1'b1;
        tick(2);

        // Foreign index: ignored entirely
        req_period = 2;
        start_dl(8'h01);
        for (int i = 0; i < 4; i++) send_byte(25'(i), 8'(8'h10 + i));
        end_dl();
        tick(20);
        check("idx1_loaded", bios_loaded, 0);
        check("idx1_hold",   cpu_hold, 1);
        check("idx1_words",  words_seen, 0);

        // Basic 8-byte image, req every 3 cycles
        req_period = 3;
        expect_word(13'd0, 16'h0201);
        expect_word(13'd1, 16'h0403);
        expect_word(13'd2, 16'h0605);
        expect_word(13'd3, 16'h0807);
        start_dl(8'h00);
        check("basic_hold_dl", cpu_hold, 1);
        for (int i = 0; i < 8; i++) send_byte(25'(i), 8'(i + 1));
        end_dl();
        wait_loaded("basic_loaded", 200);
        check("basic_hold_off", cpu_hold, 0);
        check("basic_sb_empty", sb.size(), 0);
        check("basic_ovf", overflow, 0);

        // Odd-length image padded with FF
        expect_word(13'd0, 16'hBBAA);
        expect_word(13'd1, 16'hFFCC);
        start_dl(8'h00);
        check("odd_loaded_cleared", bios_loaded, 0);
        send_byte(25'd0, 8'hAA);
        send_byte(25'd1, 8'hBB);
        send_byte(25'd2, 8'hCC);
        end_dl();
        wait_loaded("odd_loaded", 200);
        check("odd_sb_empty", sb.size(), 0);

        // Back-pressure: req held low, 64 bytes back-to-back
        req_period = 0;
        first_wait_seen = 1'b0;
        bytes_sent = 0;
        w0 = words_seen;
        for (int j = 0; j < 32; j++)
            expect_word(13'(j), {8'(8'h03 + 7 * (2 * j + 1)), 8'(8'h03 + 7 * (2 * j))});
        fork
            begin
                start_dl(8'h00);
                for (int i = 0; i < 64; i++) send_byte(25'(i), 8'(8'h03 + 7 * i));
                end_dl();
            end
            begin
                int n;
                n = 0;
                while (!ioctl_wait && n < 500) begin
                    tick();
                    n++;
                end
                check("bp_wait_rise", ioctl_wait, 1);
                tick(20);
                check("bp_wait_hold", ioctl_wait, 1);
                check("bp_no_words", words_seen - w0, 0);
                req_period = 2;
            end
        join
        check("bp_first_wait_bytes", first_wait_bytes, 31);
        wait_loaded("bp_loaded", 500);
        check("bp_sb_empty", sb.size(), 0);
        check("bp_words", words_seen - w0, 32);

        // Out-of-range byte dropped, overflow sticky
        expect_word(13'd0, 16'h2211);
        expect_word(13'd1, 16'h4433);
        start_dl(8'h00);
        send_byte(25'h0000000, 8'h11);
        send_byte(25'h0000001, 8'h22);
        send_byte(25'h0004000, 8'h99);
        send_byte(25'h0000002, 8'h33);
        send_byte(25'h0000003, 8'h44);
        end_dl();
        wait_loaded("ovf_loaded", 200);
        check("ovf_flag", overflow, 1);
        check("ovf_sb_empty", sb.size(), 0);

        // Reset mid-transfer after 10 words
        req_period = 2;
        w0 = words_seen;
        abort_tx = 1'b0;
        for (int j = 0; j < 20; j++)
            expect_word(13'(j), {8'(8'h40 + 2 * j + 1), 8'(8'h40 + 2 * j)});
        fork
            begin
                start_dl(8'h00);
                check("rst_ovf_cleared", overflow, 0);
                for (int i = 0; i < 40; i++)
                    if (!abort_tx) send_byte(25'(i), 8'(8'h40 + i));
            end
            begin
                int n;
                n = 0;
                while ((words_seen - w0) < 10 && n < 500) begin
                    tick();
                    n++;
                end
                abort_tx = 1'b1;
            end
        join
        check("rst_mid_words", ((words_seen - w0) >= 10) ? 1 : 0, 1);
        @(posedge clk_sys);
        #2;
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        req_period     = 0;
        sb.delete();
        tick(2);
        check("rst_mid_wr",     bios_wr, 0);
        check("rst_mid_addr",   bios_addr, 0);
        check("rst_mid_loaded", bios_loaded, 0);
        check("rst_mid_hold",   cpu_hold, 1);
        reset_n = 1'b1;
        tick(2);
        req_period = 3;
        expect_word(13'd0, 16'hB2B1);
        expect_word(13'd1, 16'hB4B3);
        start_dl(8'h00);
        check("reload_loaded_low", bios_loaded, 0);
        send_byte(25'd0, 8'hB1);
        send_byte(25'd1, 8'hB2);
        send_byte(25'd2, 8'hB3);
        send_byte(25'd3, 8'hB4);
        end_dl();
        wait_loaded("reload_loaded", 200);
        check("reload_sb_empty", sb.size(), 0);

`ifdef BIOS_LOADER_CHECKSUM_EN
        req_period = 2;
        expect_word(13'd0, 16'hFF01);
        start_dl(8'h00);
        send_byte(25'd0, 8'h01);
        send_byte(25'd1, 8'hFF);
        end_dl();
        wait_loaded("cks_good_loaded", 200);
        check("cks_good_ok", checksum_ok, 1);
        expect_word(13'd0, 16'h0201);
        start_dl(8'h00);
        send_byte(25'd0, 8'h01);
        send_byte(25'd1, 8'h02);
        end_dl();
        tick(40);
        check("cks_bad_sb_empty", sb.size(), 0);
        check("cks_bad_loaded", bios_loaded, 0);
        check("cks_bad_ok", checksum_ok, 0);
        check("cks_bad_hold", cpu_hold, 1);
        check("cks_bad_state", dut.r_state, IDLE);
`endif

        tick(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
